// File: rtl/mac_array_seq_if.sv
// Command/buffer/array control bundle between the host-side environment and the
// mac-array sequencer. The master side drives commands and buffer readiness; the
// slave side is the sequencer itself.
interface mac_array_seq_if #(
    parameter int unsigned N   = 4,
    parameter int unsigned K_W = 8
);
    localparam int unsigned RW = $clog2(N);

    logic           start;
    logic [K_W-1:0] k_len;
    logic           abort;
    logic           buf_rdy;
    logic           buf_rd_en;
    logic [K_W-1:0] buf_rd_addr;
    logic [N-1:0]   lane_valid;
    logic [N-1:0]   lane_init;
    logic           cap_en;
    logic [RW-1:0]  cap_row;
    logic           busy;
    logic           done;
    logic           err;

    // Host / datapath side
    modport master (
        output start, k_len, abort, buf_rdy,
        input  buf_rd_en, buf_rd_addr, lane_valid, lane_init, cap_en, cap_row,
               busy, done, err
    );

    // Sequencer side
    modport slave (
        input  start, k_len, abort, buf_rdy,
        output buf_rd_en, buf_rd_addr, lane_valid, lane_init, cap_en, cap_row,
               busy, done, err
    );
endinterface

// File: rtl/mac_array_seq.sv
// Sequencer for an N x N systolic mac grid: issues K operand reads, builds the
// skewed valid/init wavefront, waits for it to flush, then steps row capture.
module mac_array_seq #(
    parameter int unsigned N   = 4,
    parameter int unsigned K_W = 8
) (
    input logic           clk,
    input logic           rst,
    mac_array_seq_if.slave ctrl_io
);
    localparam int unsigned RW = $clog2(N);
    // Shared counter covers both the 2N-cycle flush and the N-cycle drain.
    localparam int unsigned CW = $clog2(2 * N);

    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StDrain, StDone} state_e;

    state_e         state_q, state_d;
    logic [K_W-1:0] addr_q, addr_d;
    logic [K_W-1:0] k_q, k_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   valid_q, init_q;
    logic           err_q, err_d;
    logic           rd_en;
    logic           clr_skew;
    logic           cap_en;
    logic           done;

    // Next-state, counters and decoded control outputs.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        rd_en    = 1'b0;
        clr_skew = 1'b0;
        cap_en   = 1'b0;
        done     = 1'b0;
        case (state_q)
            StIdle: begin
                if (ctrl_io.start) begin
                    if (ctrl_io.k_len != '0) begin
                        k_d     = ctrl_io.k_len;
                        addr_d  = '0;
                        state_d = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                rd_en = ctrl_io.buf_rdy;
                if (ctrl_io.abort) begin
                    state_d  = StIdle;
                    clr_skew = 1'b1;
                end else if (rd_en) begin
                    // Compare before incrementing so K = 2^K_W - 1 never wraps.
                    if (addr_q == k_q - K_W'(1)) begin
                        state_d = StFlush;
                        cnt_d   = '0;
                    end else begin
                        addr_d = addr_q + K_W'(1);
                    end
                end
            end
            StFlush: begin
                if (ctrl_io.abort) begin
                    state_d  = StIdle;
                    clr_skew = 1'b1;
                end else if (cnt_q == CW'(2 * N - 1)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDrain: begin
                cap_en = 1'b1;
                if (ctrl_io.abort) begin
                    state_d  = StIdle;
                    clr_skew = 1'b1;
                end else if (cnt_q == CW'(N - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, address, depth and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Skew wavefront: lane 0 is the read strobe delayed by the buffer latency,
    // each further lane adds one cycle. Zeros shift in whenever no read issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            init_q  <= '0;
        end else if (clr_skew) begin
            valid_q <= '0;
            init_q  <= '0;
        end else begin
            valid_q <= {valid_q[N-2:0], rd_en};
            init_q  <= {init_q[N-2:0], rd_en && (addr_q == '0)};
        end
    end

    assign ctrl_io.buf_rd_en   = rd_en;
    assign ctrl_io.buf_rd_addr = addr_q;
    assign ctrl_io.lane_valid  = valid_q;
    assign ctrl_io.lane_init   = init_q;
    assign ctrl_io.cap_en      = cap_en;
    assign ctrl_io.cap_row     = cnt_q[RW-1:0];
    assign ctrl_io.busy        = (state_q != StIdle);
    assign ctrl_io.done        = done;
    assign ctrl_io.err         = err_q;
endmodule

// File: tb/tb_mac_array_seq.sv
// Bench for mac_array_seq: table of tile commands with hand-computed done
// cycles, a beat-level reference model checked every cycle, randomized tiles,
// and hand-written reset sequences.
module tb_mac_array_seq;
    localparam int unsigned N   = 4;
    localparam int unsigned K_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_array_seq_if #(.N(N), .K_W(K_W)) bus ();

    mac_array_seq #(.N(N), .K_W(K_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_io(bus)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_rd_en"}, 32'(bus.buf_rd_en), 0);
        chk({tag, "_lane_valid"}, 32'(bus.lane_valid), 0);
        chk({tag, "_lane_init"}, 32'(bus.lane_init), 0);
        chk({tag, "_cap_en"}, 32'(bus.cap_en), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    // Runs one tile. t = 0 is the cycle start is presented; the model tracks
    // beats issued and derives every output from the cycle of the last beat.
    // done_seen is the cycle offset of the done pulse, -1 if none.
    task automatic run_tile(input int k, input int stall_beat, input int stall_len,
                            input int abort_t, input bit rnd,
                            output int done_seen, output bit err_seen);
        logic         hv[0:1023];
        logic         hi[0:1023];
        int           issued;
        int           last_t;
        int           stalled;
        int           t;
        bit           rdy;
        bit           exp_rd;
        bit           in_cap;
        logic [N-1:0] ev;
        logic [N-1:0] ei;
        issued    = 0;
        last_t    = -1;
        stalled   = 0;
        done_seen = -1;
        err_seen  = 1'b0;

        @(negedge clk);
        bus.start   = 1'b1;
        bus.k_len   = K_W'(k);
        bus.abort   = 1'b0;
        bus.buf_rdy = 1'b1;
        #1;
        chk("accept_idle_busy", 32'(bus.busy), 0);

        if (k == 0) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            err_seen = bus.err;
            chk_quiet("zero_k");
            @(negedge clk);
            #1;
            chk("err_width", 32'(bus.err), 0);
            chk_quiet("zero_k_after");
            return;
        end

        for (t = 1; t < 1000; t++) begin
            @(negedge clk);
            bus.start = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.k_len = rnd ? K_W'($urandom) : K_W'(0);
            bus.abort = (t == abort_t);
            if (rnd) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else if (issued == stall_beat && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = 1'b1;
            end
            bus.buf_rdy = rdy;
            #1;

            exp_rd = (last_t < 0) && rdy;
            hv[t]  = exp_rd;
            hi[t]  = exp_rd && (issued == 0);
            for (int i = 0; i < int'(N); i++) begin
                ev[i] = (t - 1 - i >= 1) ? hv[t-1-i] : 1'b0;
                ei[i] = (t - 1 - i >= 1) ? hi[t-1-i] : 1'b0;
            end
            in_cap = (last_t >= 0) && (t >= last_t + 2 * int'(N) + 1) &&
                     (t <= last_t + 3 * int'(N));

            chk("rd_en", 32'(bus.buf_rd_en), 32'(exp_rd));
            if (exp_rd) chk("rd_addr", 32'(bus.buf_rd_addr), 32'(issued));
            chk("lane_valid", 32'(bus.lane_valid), 32'(ev));
            chk("lane_init", 32'(bus.lane_init), 32'(ei));
            chk("cap_en", 32'(bus.cap_en), 32'(in_cap));
            if (in_cap) chk("cap_row", 32'(bus.cap_row), 32'(t - last_t - 2 * int'(N) - 1));
            chk("done", 32'(bus.done), 32'((last_t >= 0) && (t == last_t + 3 * int'(N) + 1)));
            chk("busy", 32'(bus.busy), 1);
            chk("err", 32'(bus.err), 0);
            if (bus.done) done_seen = t;

            if (t == abort_t) begin
                @(negedge clk);
                bus.abort = 1'b0;
                bus.start = 1'b0;
                #1;
                chk_quiet("post_abort");
                return;
            end
            if (exp_rd) begin
                issued++;
                if (issued == k) last_t = t;
            end
            if (last_t >= 0 && t == last_t + 3 * int'(N) + 1) return;
        end
        vectors++;
        errors++;
        $display("FAIL tile_timeout: k=%0d still running after %0d cycles", k, t);
    endtask

    typedef struct {
        int k;
        int stall_beat;
        int stall_len;
        int abort_t;
        int exp_done;
        bit exp_err;
    } vec_t;

    vec_t tbl[7];
    int   d;
    bit   e;
    int   k;
    int   ab;

    initial begin
        // exp_done is the done cycle counting the start cycle as 0, i.e. the
        // pulse lands in cycle 1 + K + 2N + N + 1 when the start cycle is 1.
        tbl[0] = '{3,   -1, 0, 0, 16,  1'b0};  // plain K=3
        tbl[1] = '{5,    2, 2, 0, 20,  1'b0};  // 2-cycle stall before beat 2
        tbl[2] = '{0,   -1, 0, 0, -1,  1'b1};  // rejected depth
        tbl[3] = '{6,   -1, 0, 9, -1,  1'b0};  // abort during flush
        tbl[4] = '{2,   -1, 0, 0, 15,  1'b0};  // restart after abort
        tbl[5] = '{1,   -1, 0, 0, 14,  1'b0};  // minimum depth, back-to-back
        tbl[6] = '{255, -1, 0, 0, 268, 1'b0};  // maximum depth, no wrap

        bus.start   = 1'b0;
        bus.k_len   = '0;
        bus.abort   = 1'b0;
        bus.buf_rdy = 1'b0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("in_reset");
        chk("in_reset_err", 32'(bus.err), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("after_reset");

        for (int i = 0; i < 7; i++) begin
            run_tile(tbl[i].k, tbl[i].stall_beat, tbl[i].stall_len, tbl[i].abort_t, 1'b0, d, e);
            chk($sformatf("vec%0d_done_cycle", i), 32'(d), 32'(tbl[i].exp_done));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
        end

        // Asynchronous reset in the middle of LOAD, between clock edges.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.k_len   = K_W'(10);
        bus.buf_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        chk("midload_busy", 32'(bus.busy), 1);
        chk("midload_valid0", 32'(bus.lane_valid[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("async_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("async_reset_release");

        // Randomized tiles with random ready, stray starts and occasional aborts.
        for (int r = 0; r < 10; r++) begin
            k  = $urandom_range(1, 12);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(2, k + 2 * N) : 0;
            run_tile(k, -1, 0, ab, 1'b1, d, e);
            chk("rand_err", 32'(e), 0);
            if (ab != 0) chk("rand_abort_no_done", 32'(d), 32'(-1));
        end

        // Closing tile after random traffic must still complete normally.
        run_tile(4, -1, 0, 0, 1'b0, d, e);
        chk("final_done_cycle", 32'(d), 17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
